// File: rtl/sr_checker_if.sv
// sr_checker_if: s/r stimulus bus between a bench driver, the sr flip-flop and
// its response checker.
//   s, r   : set/reset inputs driven to the sr flop
//   q, qn  : sr flop outputs
// Modports: master drives s/r, slave (the sr flop) drives q/qn, and monitor
// observes everything (used by sr_checker).
interface sr_checker_if;
  logic s;
  logic r;
  logic q;
  logic qn;

  modport master  (output s, r, input  q, qn);
  modport slave   (input  s, r, output q, qn);
  modport monitor (input  s, r, q, qn);
endinterface

// File: rtl/sr_checker.sv
// sr_checker: response checker for the sr flip-flop. Samples s/r into a golden
// model, compares the flop's q/qn DUT_LAT cycles later, counts mismatches and
// invalid (s=r=1) inputs, and records the cycle of the first error.
// Ports:
//   clk, rst_n       clock (posedge) and asynchronous active-low reset
//   en               checking enable
//   clr              synchronous clear of counters/err/first_err_cycle, exits FAIL
//   sr               s/r/q/qn bus (monitor modport)
//   err              sticky error flag (state == FAIL)
//   state            00 IDLE, 01 WARM, 10 CHECK, 11 FAIL
//   mismatch_cnt     saturating q/qn mismatch count
//   invalid_cnt      saturating count of sampled s=r=1 cycles
//   first_err_cycle  cycle counter value at the first mismatch
module sr_checker #(
  parameter int DUT_LAT = 1,
  parameter int CW      = 8,
  parameter int TW      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  sr_checker_if.monitor        sr,
  output logic                 err,
  output logic [1:0]           state,
  output logic [CW-1:0]        mismatch_cnt,
  output logic [CW-1:0]        invalid_cnt,
  output logic [TW-1:0]        first_err_cycle
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WARM  = 2'b01,
    CHECK = 2'b10,
    FAIL  = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        mcnt_q, mcnt_d;
  logic [CW-1:0]        icnt_q, icnt_d;
  logic [TW-1:0]        ferr_q, ferr_d;
  logic [TW-1:0]        cyc_q, cyc_d;
  logic [2:0]           warm_q, warm_d;
  logic                 model_q_q, model_q_d;
  logic                 model_k_q, model_k_d;
  logic [DUT_LAT-1:0]   pq_q, pq_d;
  logic [DUT_LAT-1:0]   pk_q, pk_d;

  logic                 exp_q, exp_k;
  logic                 mismatch;
  logic                 invalid;

  always_comb begin
    // Golden model of the sr flop; tracks every edge regardless of state.
    model_q_d = model_q_q;
    model_k_d = model_k_q;
    case ({sr.s, sr.r})
      2'b01:   begin model_q_d = 1'b0; model_k_d = 1'b1; end
      2'b10:   begin model_q_d = 1'b1; model_k_d = 1'b1; end
      2'b11:   model_k_d = 1'b0;
      default: ;
    endcase

    // Stage 0 takes the value computed at this edge, so the oldest stage lines
    // up with the q sampled DUT_LAT edges later.
    pq_d    = pq_q << 1;
    pk_d    = pk_q << 1;
    pq_d[0] = model_q_d;
    pk_d[0] = model_k_d;

    exp_q    = pq_q[DUT_LAT-1];
    exp_k    = pk_q[DUT_LAT-1];
    mismatch = (sr.qn == sr.q) | (exp_k & (sr.q != exp_q));
    invalid  = sr.s & sr.r & (state_q != IDLE);

    cyc_d   = cyc_q + 1'b1;
    state_d = state_q;
    warm_d  = warm_q;
    mcnt_d  = mcnt_q;
    icnt_d  = icnt_q;
    ferr_d  = ferr_q;

    if (clr) begin
      // clr outranks a same-cycle mismatch and freezes the state except FAIL.
      mcnt_d = '0;
      icnt_d = '0;
      ferr_d = '0;
      if (state_q == FAIL) state_d = IDLE;
    end else begin
      if (invalid && (icnt_q != '1)) icnt_d = icnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d = WARM;
            warm_d  = 3'(DUT_LAT);
          end
        end
        WARM: begin
          if (!en) begin
            state_d = IDLE;
          end else if (warm_q <= 3'd1) begin
            state_d = CHECK;
            warm_d  = '0;
          end else begin
            warm_d = warm_q - 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            state_d = FAIL;
            ferr_d  = cyc_q;
            if (mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
          end else if (!en) begin
            state_d = IDLE;
          end
        end
        FAIL: begin
          if (mismatch && (mcnt_q != '1)) mcnt_d = mcnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    err_d = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      mcnt_q    <= '0;
      icnt_q    <= '0;
      ferr_q    <= '0;
      cyc_q     <= '0;
      warm_q    <= '0;
      model_q_q <= 1'b0;
      model_k_q <= 1'b1;
      pq_q      <= '0;
      pk_q      <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      mcnt_q    <= mcnt_d;
      icnt_q    <= icnt_d;
      ferr_q    <= ferr_d;
      cyc_q     <= cyc_d;
      warm_q    <= warm_d;
      model_q_q <= model_q_d;
      model_k_q <= model_k_d;
      pq_q      <= pq_d;
      pk_q      <= pk_d;
    end
  end

  assign state           = state_q;
  assign err             = err_q;
  assign mismatch_cnt    = mcnt_q;
  assign invalid_cnt     = icnt_q;
  assign first_err_cycle = ferr_q;

endmodule

// File: tb/tb_sr_checker.sv
// tb_sr_checker: directed scenarios plus a randomized run for sr_checker. The
// bench plays the sr flop itself (with optional q/qn faults) and keeps a
// behavioural reference of the checker for every registered output.
module tb_sr_checker;
  localparam int DUT_LAT = 1;
  localparam int CW      = 8;
  localparam int TW      = 16;
  localparam int CMAX    = (1 << CW) - 1;
  localparam int R_IDLE = 0, R_WARM = 1, R_CHECK = 2, R_FAIL = 3;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic          err;
  logic [1:0]    state;
  logic [CW-1:0] mismatch_cnt;
  logic [CW-1:0] invalid_cnt;
  logic [TW-1:0] first_err_cycle;

  sr_checker_if sr_bus ();

  sr_checker #(.DUT_LAT(DUT_LAT), .CW(CW), .TW(TW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .clr             (clr),
    .sr              (sr_bus),
    .err             (err),
    .state           (state),
    .mismatch_cnt    (mismatch_cnt),
    .invalid_cnt     (invalid_cnt),
    .first_err_cycle (first_err_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  typedef struct { bit q; bit k; } gold_t;
  gold_t pipe[$];
  bit    g_q, g_k;
  int    r_state, r_warm, r_mcnt, r_icnt, r_ferr, r_cyc;
  bit    dut_q;   // emulated sr flop output

  task automatic ckeq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic ref_reset();
    pipe.delete();
    for (int i = 0; i < DUT_LAT; i++) pipe.push_back('{q: 1'b0, k: 1'b0});
    g_q = 0; g_k = 1;
    r_state = R_IDLE; r_warm = 0; r_mcnt = 0; r_icnt = 0; r_ferr = 0; r_cyc = 0;
    dut_q = 0;
  endtask

  task automatic ref_step(input bit s_i, r_i, q_i, qn_i, en_i, clr_i);
    gold_t e;
    bit    mm;
    int    nst;
    e  = pipe.pop_front();
    mm = (qn_i == q_i) || (e.k && (q_i != e.q));
    if (s_i && !r_i) begin g_q = 1; g_k = 1; end
    else if (!s_i && r_i) begin g_q = 0; g_k = 1; end
    else if (s_i && r_i) g_k = 0;
    pipe.push_back('{q: g_q, k: g_k});
    nst = r_state;
    if (clr_i) begin
      r_mcnt = 0; r_icnt = 0; r_ferr = 0;
      if (r_state == R_FAIL) nst = R_IDLE;
    end else begin
      if (s_i && r_i && r_state != R_IDLE && r_icnt < CMAX) r_icnt++;
      if (r_state == R_IDLE) begin
        if (en_i) begin nst = R_WARM; r_warm = DUT_LAT; end
      end else if (r_state == R_WARM) begin
        if (!en_i) nst = R_IDLE;
        else begin
          r_warm--;
          if (r_warm == 0) nst = R_CHECK;
        end
      end else if (r_state == R_CHECK) begin
        if (mm) begin
          nst = R_FAIL; r_ferr = r_cyc;
          if (r_mcnt < CMAX) r_mcnt++;
        end else if (!en_i) nst = R_IDLE;
      end else begin
        if (mm && r_mcnt < CMAX) r_mcnt++;
      end
    end
    r_state = nst;
    r_cyc   = (r_cyc + 1) % (1 << TW);
  endtask

  task automatic check_all();
    ckeq("state", 32'(state), 32'(r_state));
    ckeq("err", 32'(err), 32'(r_state == R_FAIL));
    ckeq("mismatch_cnt", 32'(mismatch_cnt), 32'(r_mcnt));
    ckeq("invalid_cnt", 32'(invalid_cnt), 32'(r_icnt));
    ckeq("first_err_cycle", 32'(first_err_cycle), 32'(r_ferr));
  endtask

  // One clock: drive at negedge, sample edge, check 1 time unit after.
  task automatic tick(input bit s_i, r_i, en_i, clr_i, fq, fqn);
    bit qv, qnv;
    sr_bus.s = s_i; sr_bus.r = r_i; en = en_i; clr = clr_i;
    qv  = dut_q ^ fq;
    qnv = fqn ? qv : ~qv;
    sr_bus.q = qv; sr_bus.qn = qnv;
    @(posedge clk);
    ref_step(s_i, r_i, qv, qnv, en_i, clr_i);
    if (s_i && !r_i) dut_q = 1;
    else if (!s_i && r_i) dut_q = 0;
    else if (s_i && r_i) dut_q = 1'($urandom_range(0, 1));
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; en = 0; clr = 0;
    sr_bus.s = 0; sr_bus.r = 0; sr_bus.q = 0; sr_bus.qn = 1;
    ref_reset();
    #2 check_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; en = 0; clr = 0;
    sr_bus.s = 0; sr_bus.r = 0; sr_bus.q = 0; sr_bus.qn = 1;

    // 1: warm-up and clean checking.
    do_reset();
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    ckeq("t1_state_check", 32'(state), 32'd2);
    ckeq("t1_err", 32'(err), 32'd0);

    // 2: first error at cycle 7, later errors bump only the count.
    do_reset();
    while (r_cyc != 7) tick(1, 0, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 1, 0);
    ckeq("t2_first_err_cycle", 32'(first_err_cycle), 32'd7);
    ckeq("t2_state_fail", 32'(state), 32'd3);
    tick(1, 0, 1, 0, 1, 0);
    tick(1, 0, 0, 0, 1, 0);
    ckeq("t2_mcnt", 32'(mismatch_cnt), 32'd3);
    ckeq("t2_ferr_frozen", 32'(first_err_cycle), 32'd7);

    // 3: invalid inputs counted, unknown q not compared, then a real miss.
    do_reset();
    tick(0, 1, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    ckeq("t3_invalid", 32'(invalid_cnt), 32'd2);
    ckeq("t3_err0", 32'(err), 32'd0);
    tick(1, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 1, 0);
    ckeq("t3_err1", 32'(err), 32'd1);

    // 4: qn==q mismatch, then clr leaves FAIL.
    do_reset();
    tick(0, 1, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 1);
    ckeq("t4_mcnt", 32'(mismatch_cnt), 32'd1);
    tick(0, 0, 1, 1, 0, 1);
    ckeq("t4_clr_idle", 32'(state), 32'd0);

    // 5: saturation.
    do_reset();
    tick(0, 1, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) tick(0, 0, 1, 0, 1, 0);
    ckeq("t5_saturate", 32'(mismatch_cnt), 32'd255);

    // 6: async reset while in FAIL.
    rst_n = 0;
    ref_reset();
    #2 check_all();
    ckeq("t6_state_idle", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Randomized run.
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 23) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
